// File: rtl/param_reg_file.sv
// param_reg_file: parametrised register file with byte-lane write strobes,
// read-before-write on simultaneous access, out-of-range address detection
// and a 1- or 2-stage read pipeline. Registers 0..NUM_EXPORT-1 are exported
// continuously for the ALU / UART / clock divider.
// Optional feature: define PARAM_REG_FILE_PARITY_EN to add one even-parity
// bit per byte lane, the Par_Err read-check output and the Par_Inject test input.
module param_reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_EXPORT = 4,
  parameter logic [NUM_EXPORT*DATA_WIDTH-1:0] RESET_IMAGE = {8'h20, 8'h81, 8'h00, 8'h00},
  parameter int RD_LATENCY = 1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             WrEn,
  input  logic                             RdEn,
  input  logic [ADDR_WIDTH-1:0]            Address,
  input  logic [DATA_WIDTH-1:0]            WrData,
  input  logic [DATA_WIDTH/8-1:0]          WrStrb,
  output logic [DATA_WIDTH-1:0]            RdData,
  output logic                             RdData_Valid,
  output logic                             Addr_Err,
`ifdef PARAM_REG_FILE_PARITY_EN
  input  logic                             Par_Inject,
  output logic                             Par_Err,
`endif
  output logic [NUM_EXPORT*DATA_WIDTH-1:0] Export_Regs
);

  localparam int LANES = DATA_WIDTH / 8;

  // Even parity per byte lane: the stored bit makes each lane+bit have an even count of ones.
  function automatic logic [LANES-1:0] lane_parity(input logic [DATA_WIDTH-1:0] w);
    logic [LANES-1:0] p;
    for (int b = 0; b < LANES; b++) p[b] = ^w[8*b +: 8];
    return p;
  endfunction

  // Full address value is used for the range check, including bits above log2(DEPTH).
  logic [31:0] addr_ext;
  logic        in_range;
  assign addr_ext = 32'(Address);
  assign in_range = (addr_ext < 32'(DEPTH));

  logic [DATA_WIDTH-1:0] mem_q   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d   [DEPTH];
  logic [DATA_WIDTH-1:0] rst_val [DEPTH];

  // Reset image: exported registers take their slice of RESET_IMAGE, the rest clear.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rst_val
    if (gi < NUM_EXPORT) begin : g_img
      assign rst_val[gi] = RESET_IMAGE[gi*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_zero
      assign rst_val[gi] = '0;
    end
  end

  // Exported registers are wired straight from the array, independent of read latency.
  for (genvar gi = 0; gi < NUM_EXPORT; gi++) begin : g_export
    assign Export_Regs[gi*DATA_WIDTH +: DATA_WIDTH] = mem_q[gi];
  end

  // Strobed write: only enabled lanes of the addressed in-range register change.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (WrEn && in_range && (addr_ext == 32'(i))) begin
        for (int b = 0; b < LANES; b++) begin
          if (WrStrb[b]) mem_d[i][8*b +: 8] = WrData[8*b +: 8];
        end
      end
    end
  end

  // Register array; reset dominates any concurrent write.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (RST) mem_q[i] <= rst_val[i];
      else     mem_q[i] <= mem_d[i];
    end
  end

  // Read mux on the pre-write contents; an out-of-range address matches nothing and yields 0.
  logic [DATA_WIDTH-1:0] rd_word;
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_ext == 32'(i)) rd_word = mem_q[i];
    end
  end

`ifdef PARAM_REG_FILE_PARITY_EN
  logic [LANES-1:0] par_q   [DEPTH];
  logic [LANES-1:0] par_d   [DEPTH];
  logic [LANES-1:0] wr_par;
  logic [LANES-1:0] rd_par;
  assign wr_par = lane_parity(WrData) ^ {LANES{Par_Inject}};

  // Parity bits follow the same strobed write as the data lanes they cover.
  always_comb begin
    rd_par = '0;
    for (int i = 0; i < DEPTH; i++) begin
      par_d[i] = par_q[i];
      if (addr_ext == 32'(i)) rd_par = par_q[i];
      if (WrEn && in_range && (addr_ext == 32'(i))) begin
        for (int b = 0; b < LANES; b++) begin
          if (WrStrb[b]) par_d[i][b] = wr_par[b];
        end
      end
    end
  end

  // Parity storage; reset values carry correct parity.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (RST) par_q[i] <= lane_parity(rst_val[i]);
      else     par_q[i] <= par_d[i];
    end
  end
`endif

  // First response stage: one slot per request, RdData held between reads.
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_err_q,   s1_err_d;
  logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;
`ifdef PARAM_REG_FILE_PARITY_EN
  logic                  s1_perr_q,  s1_perr_d;
`endif

  // Next-state for the first stage; errored read and write share one Addr_Err pulse.
  always_comb begin
    s1_valid_d = RdEn;
    s1_err_d   = (RdEn || WrEn) && !in_range;
    s1_data_d  = RdEn ? rd_word : s1_data_q;
`ifdef PARAM_REG_FILE_PARITY_EN
    s1_perr_d  = RdEn && in_range && (lane_parity(rd_word) != rd_par);
`endif
  end

  // First stage flops; reset flushes anything in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
`ifdef PARAM_REG_FILE_PARITY_EN
      s1_perr_q  <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      s1_data_q  <= s1_data_d;
`ifdef PARAM_REG_FILE_PARITY_EN
      s1_perr_q  <= s1_perr_d;
`endif
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_err_q,   s2_err_d;
    logic [DATA_WIDTH-1:0] s2_data_q,  s2_data_d;
`ifdef PARAM_REG_FILE_PARITY_EN
    logic                  s2_perr_q,  s2_perr_d;
`endif

    // Second stage forwards the slot and captures data only on a valid response.
    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_err_d   = s1_err_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
`ifdef PARAM_REG_FILE_PARITY_EN
      s2_perr_d  = s1_perr_q;
`endif
    end

    // Second stage flops; reset flushes it as well.
    always_ff @(posedge CLK) begin
      if (RST) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_data_q  <= '0;
`ifdef PARAM_REG_FILE_PARITY_EN
        s2_perr_q  <= 1'b0;
`endif
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_err_q   <= s2_err_d;
        s2_data_q  <= s2_data_d;
`ifdef PARAM_REG_FILE_PARITY_EN
        s2_perr_q  <= s2_perr_d;
`endif
      end
    end

    assign RdData       = s2_data_q;
    assign RdData_Valid = s2_valid_q;
    assign Addr_Err     = s2_err_q;
`ifdef PARAM_REG_FILE_PARITY_EN
    assign Par_Err      = s2_perr_q;
`endif
  end else begin : g_lat1
    assign RdData       = s1_data_q;
    assign RdData_Valid = s1_valid_q;
    assign Addr_Err     = s1_err_q;
`ifdef PARAM_REG_FILE_PARITY_EN
    assign Par_Err      = s1_perr_q;
`endif
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench for param_reg_file: a driver issues directed then random
// requests and pushes the expected response of each into a queue; a monitor
// pops and compares whenever the DUT presents a response, and also checks
// Export_Regs, RdData hold and reset outputs every cycle.
module tb_param_reg_file;

  localparam int DW    = 16;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int NE    = 4;
  localparam int LAT   = 2;
  localparam logic [NE*DW-1:0] IMG = {16'h2020, 16'h0081, 16'hBEEF, 16'h0000};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     address = '0;
  logic [DW-1:0]     wr_data = '0;
  logic [DW/8-1:0]   wr_strb = '0;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic              addr_err;
  logic [NE*DW-1:0]  export_regs;
`ifdef PARAM_REG_FILE_PARITY_EN
  logic              par_inject = 1'b0;
  logic              par_err;
`endif

  always #5 clk = ~clk;

  param_reg_file #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_EXPORT(NE),
    .RESET_IMAGE(IMG), .RD_LATENCY(LAT)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .WrEn(wr_en),
    .RdEn(rd_en),
    .Address(address),
    .WrData(wr_data),
    .WrStrb(wr_strb),
    .RdData(rd_data),
    .RdData_Valid(rd_valid),
    .Addr_Err(addr_err),
`ifdef PARAM_REG_FILE_PARITY_EN
    .Par_Inject(par_inject),
    .Par_Err(par_err),
`endif
    .Export_Regs(export_regs)
  );

  typedef struct {
    logic          valid;
    logic          err;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         exp_q[$];
  logic [DW-1:0] model [DEPTH];
  logic [NE*DW-1:0] img_v;
  logic [DW-1:0] hold_data = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    img_v = IMG;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < NE) model[k] = img_v[k*DW +: DW];
      else        model[k] = '0;
    end
  endtask

  function automatic logic [NE*DW-1:0] model_export();
    logic [NE*DW-1:0] e;
    for (int k = 0; k < NE; k++) e[k*DW +: DW] = model[k];
    return e;
  endfunction

  // One request cycle: drive at negedge, queue the expected response, then apply the write to the model.
  task automatic cycle(input bit r, input bit wr, input bit rd, input int addr,
                       input logic [DW-1:0] wd, input logic [DW/8-1:0] strb);
    resp_t e;
    bit    inr;
    @(negedge clk);
    rst = r; wr_en = wr; rd_en = rd; address = AW'(addr); wr_data = wd; wr_strb = strb;
    $display("req rst=%0b wr=%0b rd=%0b addr=%0d wdata=%h strb=%b", r, wr, rd, addr, wd, strb);
    if (r) begin
      exp_q.delete();
      model_reset();
    end else begin
      inr = (addr < DEPTH);
      if (rd || (wr && !inr)) begin
        e.valid = rd;
        e.err   = !inr;
        e.data  = (rd && inr) ? model[addr] : '0;
        exp_q.push_back(e);
      end
      if (wr && inr) begin
        for (int b = 0; b < DW/8; b++)
          if (strb[b]) model[addr][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  always @(posedge clk) begin
    resp_t e;
    #1;
    chk("export_regs", export_regs, model_export());
    if (rst) begin
      chk("reset_outputs", {rd_data, rd_valid, addr_err}, '0);
      hold_data = '0;
    end else if (rd_valid || addr_err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_response", {rd_valid, addr_err}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("valid", rd_valid, e.valid);
        chk("addr_err", addr_err, e.err);
        if (e.valid) begin
          chk("rd_data", rd_data, e.data);
          hold_data = e.data;
        end else begin
          chk("rd_data_hold_err", rd_data, hold_data);
        end
        $display("resp valid=%0b err=%0b data=%h", rd_valid, addr_err, rd_data);
      end
    end else begin
      chk("rd_data_hold", rd_data, hold_data);
    end
  end

  initial begin
    model_reset();
    cycle(1, 0, 0, 0, '0, '0);
    cycle(1, 0, 0, 0, '0, '0);
    // reset image readback
    for (int a = 0; a < 4; a++) cycle(0, 0, 1, a, '0, '0);
    // strobed writes
    cycle(0, 1, 0, 5, 16'hFFFF, 2'b11);
    cycle(0, 1, 0, 5, 16'h1234, 2'b01);
    cycle(0, 0, 1, 5, '0, '0);
    cycle(0, 1, 0, 6, 16'hABCD, 2'b00);
    cycle(0, 0, 1, 6, '0, '0);
    // simultaneous read and write: read returns old value
    cycle(0, 1, 1, 1, 16'h3C3C, 2'b11);
    cycle(0, 0, 1, 1, '0, '0);
    // out of range
    cycle(0, 0, 1, 13, '0, '0);
    cycle(0, 1, 0, 12, 16'hFFFF, 2'b11);
    cycle(0, 1, 1, 15, 16'h5555, 2'b11);
    cycle(0, 0, 0, 0, '0, '0);
    // back-to-back reads
    cycle(0, 0, 1, 2, '0, '0);
    cycle(0, 0, 1, 3, '0, '0);
    cycle(0, 0, 1, 2, '0, '0);
    cycle(0, 0, 0, 0, '0, '0);
    cycle(0, 0, 0, 0, '0, '0);
    // reset in the cycle after a read request flushes it
    cycle(0, 1, 1, 2, 16'h7777, 2'b11);
    cycle(1, 1, 1, 3, 16'h8888, 2'b11);
    cycle(0, 0, 0, 0, '0, '0);
    cycle(0, 0, 0, 0, '0, '0);
    // random traffic
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 15)), DW'($urandom), 2'($urandom));
    end
    for (int n = 0; n < LAT + 2; n++) cycle(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_reg_file.md
Name: param_reg_file

Overview:
- Parametrised successor of the system register file; holds ALU operands, UART config and divider ratio, plus general-purpose storage.
- Generalised in width, depth, exported-register count and reset image.
- Adds byte-lane write strobes, a concurrent read-before-write path, out-of-range address detection and a configurable read pipeline.
- Sits between the system controller (read/write requests) and the ALU/UART/clock-divider (exported config registers).

Parameters:
- DATA_WIDTH, 8, register width in bits; must be a multiple of 8.
- DEPTH, 16, number of implemented registers (need not be a power of 2).
- ADDR_WIDTH, 4, address bus width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- NUM_EXPORT, 4, registers 0..NUM_EXPORT-1 driven continuously on Export_Regs; range 1..DEPTH.
- RESET_IMAGE, {8'h20,8'h81,8'h00,8'h00}, NUM_EXPORT*DATA_WIDTH reset values. Register k resets to bits [k*DATA_WIDTH +: DATA_WIDTH]. Default: reg2 = prescale 32, parity enabled, even; reg3 = 32.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RST  in  1  synchronous reset, active-high.
- WrEn  in  1  write request.
- RdEn  in  1  read request.
- Address  in  ADDR_WIDTH  register index for both read and write.
- WrData  in  DATA_WIDTH  write data.
- WrStrb  in  DATA_WIDTH/8  byte-lane write enables; lane b covers bits [8b+7:8b].
- RdData  out  DATA_WIDTH  read data; holds its last value between reads.
- RdData_Valid  out  1  one-cycle pulse, aligned with RdData.
- Addr_Err  out  1  one-cycle pulse, aligned with the response slot of an errored access.
- Export_Regs  out  NUM_EXPORT*DATA_WIDTH  live contents of registers 0..NUM_EXPORT-1.

Behaviour:
- Reset (RST=1 at a clock edge):
  - Registers 0..NUM_EXPORT-1 load RESET_IMAGE; all others load 0.
  - RdData=0, RdData_Valid=0, Addr_Err=0.
  - The read pipeline is flushed, so any read in flight is discarded with no valid pulse.
  - RST has priority over WrEn and RdEn.
- Write (WrEn=1, Address<DEPTH):
  - Each lane with WrStrb[b]=1 updates at the edge; lanes with WrStrb[b]=0 keep their value.
  - WrStrb=0 is a legal no-op write and raises no error.
- Read (RdEn=1, Address<DEPTH):
  - The array is sampled at the request edge.
  - RD_LATENCY=1: RdData and RdData_Valid update at that edge, i.e. visible the cycle after the request.
  - RD_LATENCY=2: one extra register stage, visible two cycles after the request.
  - Back-to-back reads are fully pipelined at one per cycle with no bubbles.
- Simultaneous WrEn=1 and RdEn=1 (same address):
  - Both operations are performed (the previous generation dropped both).
  - The read returns the pre-write contents (read-before-write); the write lands at the same edge.
- Out-of-range access (Address>=DEPTH):
  - Write: ignored; no array change.
  - Read: returns RdData=0 with RdData_Valid=1 at the normal latency.
  - Addr_Err pulses in the response slot: the write's slot for writes, the read's slot for reads. Write-response slot = the same latency as a read.
  - Simultaneous errored read and write produce a single Addr_Err pulse.
- Idle (WrEn=0, RdEn=0): RdData_Valid=0 and Addr_Err=0 at the next response slot; RdData holds.
- Export_Regs:
  - Combinational from the array, so a write is visible the cycle after its edge.
  - Unaffected by read latency.
- Address bits above those needed for DEPTH are still compared, so the full address value is used in the range check.

Optional Feature:
- Macro: PARAM_REG_FILE_PARITY_EN.
- Defined:
  - Each register stores an extra even-parity bit per byte lane, computed on every write of that lane; reset values store correct parity.
  - On read, the stored parity is checked; a mismatch drives extra output Par_Err (1 bit), a pulse aligned with RdData_Valid.
  - Data is still returned on a mismatch.
  - A test-only input Par_Inject (1 bit) inverts the computed parity for lanes written while it is high.
- Undefined: Par_Err and Par_Inject ports are absent; no parity storage.

Test Plan:
- Reset then read addresses 0..3, DEPTH=16, RD_LATENCY=1 -> RdData 00,00,81,20 each one cycle after its request; Export_Regs=32'h20810000.
- Write 8'hA5 to addr 5 with WrStrb=1, then read addr 5 -> RdData=A5 with one RdData_Valid pulse; DATA_WIDTH=16 variant: write 16'h1234 strb 2'b01 over 16'hFFFF -> read 16'hFF34.
- Write 8'h3C to addr 1 and read addr 1 in the same cycle (old value 8'h00) -> RdData=00; next read of addr 1 returns 3C; Export_Regs[15:8]=3C the cycle after the write.
- DEPTH=12: read addr 13 -> RdData=0, RdData_Valid=1, Addr_Err=1 together; write 8'hFF to addr 12 -> Addr_Err pulse, no register changes.
- RD_LATENCY=2: reads of addrs 2,3,2 on consecutive cycles -> valid on 3 consecutive cycles starting 2 cycles after the first, data 81,20,81; RST asserted in the cycle after the first request -> no valid pulses, outputs 0.
- Parity build: write 8'h01 with Par_Inject=1, then read -> Par_Err=1 with RdData=01; rewrite with Par_Inject=0, then read -> Par_Err=0.
